data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/dm_pkg.sv | 15 +
 rtl/dm_sram.sv | 23 ++
 rtl/data_mem_responder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// the out-of-range read pattern and default sizing.
package dm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dm_state_e;

  localparam logic [31:0] DM_ERR_PATTERN   = 32'hDEADBEEF;
  localparam int          DM_DEPTH_DEFAULT = 1024;
  localparam int          DM_LAT_DEFAULT   = 2;

endpackage

// File: rtl/dm_sram.sv
// Word-wide single-port storage: synchronous write, asynchronous read,
// contents are never reset.
module dm_sram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Write port: commit on the rising edge when enabled
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the MEM stage.
// An accepted request stalls the pipeline for LATENCY+1 cycles; read data
// is registered on entry to DONE and held until the next DONE; writes
// commit on the edge leaving DONE, so a combined read/write returns the
// pre-write word.
// Optional: define DM_RANGE_CHECK_EN to flag addresses >= DEPTH_WORDS*4
// (write suppressed, read returns DM_ERR_PATTERN, DM_error pulses).
// Without it addresses wrap modulo DEPTH_WORDS and DM_error is 0.
module data_mem_responder
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = DM_DEPTH_DEFAULT,
  parameter int LATENCY     = DM_LAT_DEFAULT
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MemRead_2DM,
  input  logic        MemWrite_2DM,
  input  logic [31:0] data_address_2DM,
  input  logic [31:0] data_write_2DM,
  output logic [31:0] data_read_fDM,
  output logic        DM_stall,
  output logic        DM_error
);

  localparam int         AW     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  dm_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wr_q, wr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic        oor;
  logic        unused_addr_bits;

  assign req = MemRead_2DM | MemWrite_2DM;

  // While IDLE the live address is used so a zero-latency access can
  // sample the array on its accept edge; afterwards the captured one.
  assign mem_addr = (state_q == IDLE) ? data_address_2DM : addr_q;
  assign unused_addr_bits = ^{mem_addr[31:AW+2], mem_addr[1:0]};

`ifdef DM_RANGE_CHECK_EN
  assign oor = (mem_addr >= 32'(DEPTH_WORDS * 4));
`else
  assign oor = 1'b0;
`endif

  // A reset edge while in DONE abandons the pending write
  assign mem_we = (state_q == DONE) & wr_q & ~oor & ~RESET;

  dm_sram #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_sram (
    .clk   (CLK),
    .we    (mem_we),
    .addr  (mem_addr[AW+1:2]),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  // Next-state, counter, capture and read-data load
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = data_address_2DM;
          wdata_d = data_write_2DM;
          wr_d    = MemWrite_2DM;
          if (LATENCY > 0) begin
            state_d = BUSY;
            cnt_d   = LAT_M1;
          end else begin
            state_d = DONE;
            rdata_d = oor ? DM_ERR_PATTERN : mem_rdata;
            err_d   = oor;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          rdata_d = oor ? DM_ERR_PATTERN : mem_rdata;
          err_d   = oor;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wr_q    <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign DM_stall      = ~RESET & (((state_q == IDLE) & req) | (state_q == BUSY));
  assign data_read_fDM = rdata_q;
  assign DM_error      = err_q;

endmodule
